key_debounce_bank: RTL and testbench
====================================

Name: key_debounce_bank

Overview:
- Parametrised multi-channel push-button conditioner for the clock/stopwatch front panel.
- Each of N_KEYS raw mechanical inputs is synchronised and debounced. Each channel then yields a clean level, plus one-cycle pulses for press, release, long-press and auto-repeat.
- Sits between the board pins and the time-set / start-stop control logic, so those consumers never count raw bounces.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYC, 1_000_000, consecutive clk cycles a new level must hold before acceptance (20 ms at 50 MHz); must be >= 2.
- LONG_CYC, 50_000_000, held cycles after accepted press before key_long fires (1 s); must be > DEBOUNCE_CYC.
- REPEAT_CYC, 10_000_000, period of key_repeat pulses after key_long (200 ms); 0 disables repeat.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- key_raw  input  N_KEYS  raw asynchronous key pins.
- key_level  output  N_KEYS  debounced state, 1 = pressed (polarity normalised).
- key_press  output  N_KEYS  1-cycle pulse on accepted press.
- key_release  output  N_KEYS  1-cycle pulse on accepted release.
- key_long  output  N_KEYS  1-cycle pulse when press held LONG_CYC cycles.
- key_repeat  output  N_KEYS  1-cycle pulse every REPEAT_CYC cycles after key_long while still held.

Behaviour:
Interface
- One clock, clk. Reset is asynchronous and active-low on port reset.
- On reset, all outputs 0, all counters 0, all channel FSMs IDLE, synchroniser flops load the "released" value.

Input path (per channel)
- 2-flop synchroniser, then XOR with ACTIVE_LOW giving norm (1 = pressed).
- Channels are fully independent; no shared counters.

Debounce (per channel)
- dcnt counts consecutive cycles where norm != key_level.
- Any cycle with norm == key_level clears dcnt to 0. A bounce restarts the window rather than latching late.
- When dcnt == DEBOUNCE_CYC-1 and norm still differs, the next edge sets key_level <= norm and dcnt <= 0.
- Latency: raw change stable before edge k gives key_level change at edge k+2+DEBOUNCE_CYC.

Pulses
- key_press and key_release are registered. They are high for exactly the one cycle following the key_level transition edge (same edge as key_level updates).

Hold FSM (per channel)
- States: IDLE, HELD, REPEAT.
- IDLE -> HELD on accepted press. hcnt cleared to 0 on that edge, then incremented each cycle.
- HELD: when hcnt == LONG_CYC-1, pulse key_long. Clear hcnt. Go to REPEAT if REPEAT_CYC != 0, else stay in HELD with hcnt saturated, and never fire key_long again for this press.
- REPEAT: when hcnt == REPEAT_CYC-1, pulse key_repeat and clear hcnt.
- Accepted release in any state goes to IDLE and clears hcnt. If release and a long/repeat terminal count land on the same edge, release wins: no long/repeat pulse.
- LONG_CYC is measured from the key_level rise, not from the raw edge.

Widths and timing
- Counter widths: $clog2 of the largest parameter plus 1. No wrap is ever reachable.

Reset mid-operation
- Asserting reset at any time immediately forces all outputs 0 and aborts pending debounce and hold counts.
- After release, a key physically held must re-qualify for DEBOUNCE_CYC cycles. It then generates key_press.

Test Plan (bench params: N_KEYS=4, DEBOUNCE_CYC=8, LONG_CYC=40, REPEAT_CYC=16, ACTIVE_LOW=1):
- Reset then idle pins at 4'b1111 for 100 cycles -> all outputs 0 throughout.
- key_raw[0] falls to 0 before edge k and holds -> key_level[0]=1 and key_press[0]=1 at edge k+10 only; no other channel changes.
- key_raw[1] bounces 0/1 every 5 cycles for 60 cycles, then holds 0 -> no pulse during bouncing; single key_press[1] 10 cycles after the final settle.
- key_raw[2] held 0 for 120 cycles after acceptance:
  - key_long[2] 40 cycles after key_press[2].
  - key_repeat[2] at +56, +72, +88, +104, +120.
  - On release, key_release[2] once and no further repeats.
- Press key 3, then assert reset at cycle 20 of hold for 3 cycles while the pin stays 0 -> outputs 0 during reset; key_press[3] re-fires 10 cycles after reset deassert; key_long[3] 40 cycles after that.
- Keys 0 and 3 pressed on the same cycle, key 0 released while key 3 is in REPEAT -> independent pulses per channel; key_release[0] has no effect on key 3's repeat cadence.

Source files
------------

// File: rtl/key_debounce_bank_if.sv
// -----------------------------------------------------------------------------
// key_debounce_bank_if
//
// Bundles the raw key pins and the conditioned key events that travel between
// the board pins, the debounce bank and the front-panel control logic.
//
// Signals (all N_KEYS wide, one bit per key channel):
//   key_raw      raw asynchronous key pins
//   key_level    debounced pressed state, 1 = pressed
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   key_long     1-cycle pulse once a press has been held LONG_CYC cycles
//   key_repeat   1-cycle auto-repeat pulse while held after key_long
//
// Modports:
//   master  the debounce bank: reads pins, sources the key events
//   slave   pin side / consumer: drives pins, reads the key events
// -----------------------------------------------------------------------------
interface key_debounce_bank_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat
    );

    modport slave (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat
    );
endinterface

// File: rtl/key_debounce_bank.sv
// -----------------------------------------------------------------------------
// key_debounce_bank
//
// Multi-channel push-button conditioner for the clock/stopwatch front panel.
// Every raw key pin is synchronised, normalised to 1 = pressed and debounced.
// Each channel then produces a clean level plus one-cycle press, release,
// long-press and auto-repeat pulses. Channels share nothing but the clock.
//
// Ports:
//   clk    system clock, everything on the rising edge
//   reset  asynchronous, active-low reset
//   keys   key_debounce_bank_if.master: key_raw in, key_level / key_press /
//          key_release / key_long / key_repeat out (N_KEYS bits each)
//
// Timing: a raw change that is stable before edge k is reflected in key_level
// (and the matching press/release pulse) at edge k+2+DEBOUNCE_CYC. key_long
// fires LONG_CYC edges after the key_level rise. key_repeat then fires every
// REPEAT_CYC edges while the key is still held.
// -----------------------------------------------------------------------------
module key_debounce_bank #(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                clk,
    input  logic                reset,
    key_debounce_bank_if.master keys
);

    // LONG_CYC always exceeds DEBOUNCE_CYC, so only long vs. repeat matters.
    localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DEB_TERM  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] LONG_TERM = CW'(LONG_CYC - 1);
    // Parking value once key_long has fired with repeat disabled.
    // It can never equal LONG_TERM, so key_long fires only once per press.
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYC);
    localparam logic [CW-1:0] REP_TERM  = (REPEAT_CYC == 0) ? '0 : CW'(REPEAT_CYC - 1);

    // Pin value of a released key; it also serves as the XOR mask that
    // turns a pin value into "1 = pressed".
    localparam logic [N_KEYS-1:0] RELEASED = (ACTIVE_LOW != 0) ? '1 : '0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] norm_q;
    logic [N_KEYS-1:0] level_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] long_q;
    logic [N_KEYS-1:0] repeat_q;
    logic [N_KEYS-1:0] accept;

    logic [CW-1:0] dcnt   [N_KEYS];
    logic [CW-1:0] hcnt   [N_KEYS];
    logic [1:0]    hstate [N_KEYS];

    // Two-flop synchroniser followed by a registered polarity normalisation.
    // The extra normalisation stage sets the accept latency to
    // DEBOUNCE_CYC+2 edges after the pin edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= RELEASED;
            sync2  <= RELEASED;
            norm_q <= '0;
        end else begin
            sync1  <= keys.key_raw;
            sync2  <= sync1;
            norm_q <= sync2 ^ RELEASED;
        end
    end

    // A channel accepts its new level on the edge where the counter already
    // holds DEBOUNCE_CYC-1 differing cycles and the input still differs.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            accept[i] = (norm_q[i] != level_q[i]) && (dcnt[i] == DEB_TERM);
        end
    end

    // Debounce counters, level register and press/release pulses. Any cycle
    // that agrees with the current level restarts the window, so a bounce
    // never lets a stale count complete late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (norm_q[i] == level_q[i]) begin
                    dcnt[i] <= '0;
                end else if (accept[i]) begin
                    dcnt[i]    <= '0;
                    level_q[i] <= norm_q[i];
                end else begin
                    dcnt[i] <= dcnt[i] + CW'(1);
                end
                press_q[i]   <= accept[i] & norm_q[i];
                release_q[i] <= accept[i] & ~norm_q[i];
            end
        end
    end

    // Hold FSM per channel. An accepted release wins over everything else,
    // including a long/repeat terminal count landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            long_q   <= '0;
            repeat_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                hcnt[i]   <= '0;
                hstate[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                long_q[i]   <= 1'b0;
                repeat_q[i] <= 1'b0;
                if (accept[i] && !norm_q[i]) begin
                    hstate[i] <= ST_IDLE;
                    hcnt[i]   <= '0;
                end else begin
                    case (hstate[i])
                        ST_IDLE: begin
                            hcnt[i] <= '0;
                            if (accept[i] && norm_q[i]) begin
                                hstate[i] <= ST_HELD;
                            end
                        end
                        ST_HELD: begin
                            if (hcnt[i] == LONG_TERM) begin
                                long_q[i] <= 1'b1;
                                if (REPEAT_CYC != 0) begin
                                    hstate[i] <= ST_REPEAT;
                                    hcnt[i]   <= '0;
                                end else begin
                                    hcnt[i] <= LONG_SAT;
                                end
                            end else if (hcnt[i] != LONG_SAT) begin
                                hcnt[i] <= hcnt[i] + CW'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (hcnt[i] == REP_TERM) begin
                                repeat_q[i] <= 1'b1;
                                hcnt[i]     <= '0;
                            end else begin
                                hcnt[i] <= hcnt[i] + CW'(1);
                            end
                        end
                        default: begin
                            hstate[i] <= ST_IDLE;
                            hcnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign keys.key_level   = level_q;
    assign keys.key_press   = press_q;
    assign keys.key_release = release_q;
    assign keys.key_long    = long_q;
    assign keys.key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_bank
//
// Bench for key_debounce_bank with N_KEYS=4, DEBOUNCE_CYC=8, LONG_CYC=40,
// REPEAT_CYC=16, ACTIVE_LOW=1. A behavioural model predicts every output
// from the pin history: a level is accepted once the DEBOUNCE_CYC samples
// seen through the synchroniser all disagree with it, and long/repeat follow
// from how many edges have passed since acceptance. Directed scenarios pin
// exact pulse edges with hand-computed numbers. A randomised phase follows.
// -----------------------------------------------------------------------------
module tb_key_debounce_bank;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int L  = 40;
    localparam int R  = 16;
    localparam int AL = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    key_debounce_bank_if #(.N_KEYS(N)) kif ();

    key_debounce_bank #(
        .N_KEYS      (N),
        .DEBOUNCE_CYC(D),
        .LONG_CYC    (L),
        .REPEAT_CYC  (R),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .keys (kif.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    // Model state: hist[i][j] is the pressed value sampled j edges ago.
    int hist [N][D+3];
    bit m_lvl [N];
    int held [N];
    logic [N-1:0] e_level, e_press, e_release, e_long, e_repeat;

    // Pulse edge logs taken from the DUT, checked against literal numbers.
    int press_log   [N][$];
    int release_log [N][$];
    int long_log    [N][$];
    int repeat_log  [N][$];

    task automatic checkOutput(input string name, input logic [N-1:0] act,
                               input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at edge %0d: got %b, want %b", name, edge_cnt, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < D + 3; j++) hist[i][j] = 0;
            m_lvl[i] = 1'b0;
            held[i]  = 0;
        end
        e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
    endtask

    task automatic modelStep();
        bit acc;
        e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = D + 2; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = int'(kif.key_raw[i]) ^ AL;
            acc = 1'b1;
            for (int j = 3; j <= D + 2; j++) begin
                if (hist[i][j] == int'(m_lvl[i])) acc = 1'b0;
            end
            if (acc) begin
                m_lvl[i] = !m_lvl[i];
                if (m_lvl[i]) begin
                    e_press[i] = 1'b1;
                    held[i]    = 0;
                end else begin
                    e_release[i] = 1'b1;
                end
            end else if (m_lvl[i]) begin
                held[i]++;
                if (held[i] == L) e_long[i] = 1'b1;
                if (R != 0 && held[i] > L && ((held[i] - L) % R) == 0) e_repeat[i] = 1'b1;
            end
            e_level[i] = m_lvl[i];
        end
    endtask

    task automatic clearLogs();
        for (int i = 0; i < N; i++) begin
            press_log[i].delete();
            release_log[i].delete();
            long_log[i].delete();
            repeat_log[i].delete();
        end
    endtask

    // Drive the pins at a falling edge and hold them for a number of cycles.
    task automatic applyStimulus(input logic [N-1:0] raw, input int cycles);
        kif.key_raw = raw;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    // Reference model process.
    initial begin
        modelClear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) modelClear();
            else modelStep();
        end
    end

    // Per-cycle comparison plus pulse logging, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            checkOutput("key_level",   kif.key_level,   e_level);
            checkOutput("key_press",   kif.key_press,   e_press);
            checkOutput("key_release", kif.key_release, e_release);
            checkOutput("key_long",    kif.key_long,    e_long);
            checkOutput("key_repeat",  kif.key_repeat,  e_repeat);
            for (int i = 0; i < N; i++) begin
                if (kif.key_press[i])   press_log[i].push_back(edge_cnt);
                if (kif.key_release[i]) release_log[i].push_back(edge_cnt);
                if (kif.key_long[i])    long_log[i].push_back(edge_cnt);
                if (kif.key_repeat[i])  repeat_log[i].push_back(edge_cnt);
            end
        end
    end

    initial begin
        int c;
        int p;
        int d;
        int total;

        kif.key_raw = 4'b1111;
        #1 reset = 1'b0;
        @(negedge clk);
        #2;
        checkValue("reset_level", int'(kif.key_level), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Idle pins: nothing may move.
        $display("[TB] idle pins");
        clearLogs();
        applyStimulus(4'b1111, 100);
        total = 0;
        for (int i = 0; i < N; i++) begin
            total += press_log[i].size() + release_log[i].size()
                   + long_log[i].size() + repeat_log[i].size();
        end
        checkValue("idle_pulse_count", total, 0);

        // Single press on key 0: accepted DEBOUNCE_CYC+2 edges after the pin edge.
        $display("[TB] key 0 press latency");
        clearLogs();
        c = edge_cnt;
        applyStimulus(4'b1110, 20);
        checkValue("press0_count", press_log[0].size(), 1);
        checkValue("press0_edge", (press_log[0].size() > 0) ? press_log[0][0] : -1, c + 11);
        checkValue("press_others", press_log[1].size() + press_log[2].size() + press_log[3].size(), 0);
        c = edge_cnt;
        applyStimulus(4'b1111, 20);
        checkValue("release0_edge", (release_log[0].size() > 0) ? release_log[0][0] : -1, c + 11);

        // Key 1 bounces every 5 cycles, then settles pressed.
        $display("[TB] key 1 bounce");
        clearLogs();
        for (int ph = 0; ph < 12; ph++) begin
            applyStimulus((ph % 2 == 0) ? 4'b1101 : 4'b1111, 5);
        end
        c = edge_cnt;
        applyStimulus(4'b1101, 20);
        checkValue("press1_count", press_log[1].size(), 1);
        checkValue("press1_edge", (press_log[1].size() > 0) ? press_log[1][0] : -1, c + 11);
        applyStimulus(4'b1111, 20);

        // Key 2 held: long then a repeat every 16 cycles, stopped by release.
        $display("[TB] key 2 long and repeat");
        clearLogs();
        c = edge_cnt;
        p = c + 11;
        applyStimulus(4'b1011, 131);
        c = edge_cnt;
        applyStimulus(4'b1111, 30);
        checkValue("long2_count", long_log[2].size(), 1);
        checkValue("long2_edge", (long_log[2].size() > 0) ? long_log[2][0] : -1, p + 40);
        checkValue("repeat2_count", repeat_log[2].size(), 5);
        for (int j = 0; j < 5; j++) begin
            checkValue($sformatf("repeat2_edge%0d", j),
                       (repeat_log[2].size() > j) ? repeat_log[2][j] : -1, p + 56 + 16 * j);
        end
        checkValue("release2_count", release_log[2].size(), 1);
        checkValue("release2_edge", (release_log[2].size() > 0) ? release_log[2][0] : -1, c + 11);

        // Key 3: reset in the middle of a hold, pin kept pressed.
        $display("[TB] key 3 reset mid-hold");
        clearLogs();
        applyStimulus(4'b0111, 31);
        reset = 1'b0;
        #1;
        checkValue("reset_outputs_zero",
                   int'({kif.key_level, kif.key_press, kif.key_release, kif.key_long, kif.key_repeat}), 0);
        applyStimulus(4'b0111, 3);
        reset = 1'b1;
        d = edge_cnt;
        applyStimulus(4'b0111, 60);
        checkValue("press3_count", press_log[3].size(), 2);
        checkValue("press3_refire", (press_log[3].size() > 1) ? press_log[3][1] : -1, d + 11);
        checkValue("long3_edge", (long_log[3].size() > 0) ? long_log[3][0] : -1, d + 51);
        applyStimulus(4'b1111, 30);

        // Keys 0 and 3 together; key 0 released while key 3 repeats.
        $display("[TB] keys 0 and 3 independent");
        clearLogs();
        c = edge_cnt;
        p = c + 11;
        applyStimulus(4'b0110, 69);
        applyStimulus(4'b0111, 40);
        applyStimulus(4'b1111, 30);
        checkValue("long0_edge", (long_log[0].size() > 0) ? long_log[0][0] : -1, p + 40);
        checkValue("long3_same_edge", (long_log[3].size() > 0) ? long_log[3][0] : -1, p + 40);
        checkValue("release0_while3", (release_log[0].size() > 0) ? release_log[0][0] : -1, p + 69);
        checkValue("repeat0_count", repeat_log[0].size(), 1);
        checkValue("repeat3_count", repeat_log[3].size(), 4);
        for (int j = 0; j < 4; j++) begin
            checkValue($sformatf("repeat3_edge%0d", j),
                       (repeat_log[3].size() > j) ? repeat_log[3][j] : -1, p + 56 + 16 * j);
        end

        // Randomised pin activity with occasional long holds and resets.
        $display("[TB] random phase");
        for (int it = 0; it < 300; it++) begin
            logic [N-1:0] r;
            int len;
            r = 4'($urandom);
            if ($urandom_range(0, 4) == 0) len = $urandom_range(40, 90);
            else len = $urandom_range(1, 14);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                applyStimulus(r, $urandom_range(1, 3));
                reset = 1'b1;
            end
            applyStimulus(r, len);
        end
        applyStimulus(4'b1111, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
